jt1942_rom_arb: RTL and testbench
=================================

// Module: jt1942_rom_arb
// PURPOSE
//  Round-robin arbiter that shares the single 16-bit program/graphics ROM read port among NREQ requesters.
//  Requesters include the main CPU, sound CPU, char, scroll and object fetchers.
//  Sits between the game's fetch units and the dual-PROM ROM array (registered read, fixed latency).
//  Keeps one data latch plus address tag per requester, so repeated reads of the same word complete with zero latency.
//  Blocks all grants and clears every latch while a ROM download is in progress.
// PARAMETERS
//  NREQ  4   number of requesters, 2..8; index 0 wins first after reset
//  AW    17  ROM word address width
//  DW    16  ROM data width
//  LAT   1   ROM read latency in clocks, from rom_addr stable to rom_data valid; 1..3
// PORTS
//  clk          in   1        system clock; all logic on posedge
//  rst_n        in   1        asynchronous reset, active low
//  downloading  in   1        ROM download active; freezes the arbiter
//  req          in   NREQ     per-requester read request, level; hold until data_ok
//  addr         in   NREQ*AW  per-requester word address; slice i = addr[i*AW +: AW]
//  data_ok      out  NREQ     high while dout slice holds the word for the current addr
//  dout         out  NREQ*DW  per-requester data latch; slice i = dout[i*DW +: DW]
//  rom_addr     out  AW       address to ROM array (registered)
//  rom_data     in   DW       ROM array output, valid LAT clocks after rom_addr
//  busy         out  1        high while a ROM access is in flight (state WAIT)
// BEHAVIOUR
//  Reset: rom_addr=0, busy=0, dout=0, tag[i]=0, valid[i]=0, state=IDLE, last=NREQ-1.
//   Consequence: with all req set after reset, requester 0 is granted first.
//  Hit: hit[i] = req[i] & valid[i] & (addr_i == tag[i]).
//   data_ok = hit, combinational, so a hit gives zero-latency completion.
//   data_ok[i] drops in the same cycle that req[i] drops or addr_i changes.
//  Pending: pend[i] = req[i] & ~hit[i]. Only pending requesters compete for the ROM port.
//  FSM has two states, IDLE and WAIT:
//   IDLE: if ~downloading and any pend, pick the winner and go to WAIT.
//    Winner = first set pend index searching last+1, last+2, ... modulo NREQ.
//    On that edge: rom_addr <= addr_w, gnt <= w, last <= w, cnt <= LAT, busy <= 1.
//   WAIT: cnt decrements each clock. On the edge where cnt==0:
//    dout_w <= rom_data, tag[w] <= rom_addr, valid[w] <= 1, busy <= 0, state -> IDLE.
//  Miss latency: req rises in cycle 0 with the arbiter idle -> data_ok in cycle LAT+2.
//   With LAT=1 that is cycle 3.
//  A new grant can be issued on the cycle right after a capture (IDLE lasts exactly one clock).
//  Addr change in flight: capture still tags the issued address, so no false data_ok.
//   The requester re-enters arbitration on a later IDLE cycle.
//  req drop in flight: the access still completes and the latch is filled; data_ok stays 0.
//  Latch life: valid[i] is never cleared by req dropping.
//   A later req at the same address hits with zero latency.
//  downloading=1, at any state including mid-WAIT:
//   On the next edge: state -> IDLE, busy=0, valid[*]=0, no capture; data_ok=0 combinationally.
//   rom_addr holds its value; no grants are issued while downloading=1.
//  Simultaneous events: pend evaluation and latch capture use pre-edge values.
//   A requester captured on edge k hits in cycle k+1, so it never wins a redundant grant.
//  rst_n asserted mid-operation: everything returns to reset values immediately (async).
//  Width rules: cnt is 2 bits; round-robin index is $clog2(NREQ) bits, wrapping modulo NREQ.
//  Requester contract: req and addr must be stable from the cycle req rises until data_ok is seen.
// TESTING
//  1. Single miss, LAT=1: req[1]=1, addr1=17'h00123 at cycle 0, ROM word 16'hBEEF.
//     -> rom_addr=0x123 in cycle 1, data_ok[1]=1 and dout1=BEEF in cycle 3, busy high in cycles 1-2.
//  2. Hit: drop and re-raise req[1] with the same address.
//     -> data_ok[1]=1 in the same cycle; no change in busy or rom_addr.
//  3. Fairness: req[3:0]=4'hF right after reset, four distinct addresses.
//     -> grants in order 0,1,2,3, each 3 cycles apart.
//     -> Then with last=3, req={2,0} -> 0 granted before 2.
//  4. Download abort: assert downloading during WAIT for requester 2.
//     -> busy=0 next cycle, no dout2 update, all data_ok=0.
//     -> After release, requester 2 re-granted and completes.
//  5. Address change in flight: addr0 changes 0x10->0x20 during WAIT.
//     -> no data_ok for 0x20 until a second access; rom_addr=0x20 on the next grant.
//  6. LAT=3 build: single miss -> data_ok in cycle 5.

Source files
------------

// File: rtl/jt1942_rom_arb_if.sv
// Requester/ROM bus of the 1942 ROM arbiter: per-requester request, address,
// completion and data slices, plus the shared ROM read port and busy flag.
interface jt1942_rom_arb_if #(
  parameter int NREQ = 4,
  parameter int AW   = 17,
  parameter int DW   = 16
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    data_ok;
  logic [NREQ*DW-1:0] dout;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_data;
  logic               busy;

  // Fetch units plus the ROM array side
  modport master (
    output req, addr, rom_data,
    input  data_ok, dout, rom_addr, busy
  );

  // Arbiter side
  modport slave (
    input  req, addr, rom_data,
    output data_ok, dout, rom_addr, busy
  );
endinterface

// File: rtl/jt1942_rom_arb.sv
// Round-robin arbiter sharing one registered-read ROM port among NREQ fetch
// units. Each requester owns a data latch tagged with the address it holds,
// so re-reads of the same word complete combinationally. A ROM download
// cancels any access in flight and invalidates every latch.
module jt1942_rom_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 17,
  parameter int DW   = 16,
  parameter int LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               downloading,
  jt1942_rom_arb_if.slave    bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic            busy_q, busy_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0] valid_q, valid_d;
  logic [AW-1:0]   tag_q  [NREQ];
  logic [AW-1:0]   tag_d  [NREQ];
  logic [DW-1:0]   dout_q [NREQ];
  logic [DW-1:0]   dout_d [NREQ];

  logic [AW-1:0]   addr_a [NREQ];
  logic [NREQ-1:0] hit;
  logic [NREQ-1:0] pend;
  logic            win_vld;
  logic [IW-1:0]   win;
  logic [IW-1:0]   idx;

  // Unpack addresses and find latches that already hold the requested word
  always_comb begin
    hit  = '0;
    pend = '0;
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = bus.addr[i*AW +: AW];
      hit[i]    = bus.req[i] & valid_q[i] & ~downloading & (addr_a[i] == tag_q[i]);
      pend[i]   = bus.req[i] & ~hit[i];
    end
  end

  // Round-robin search starting just after the last granted requester
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_q) + k) % NREQ);
      if (!win_vld && pend[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  // Next-state logic: grant in IDLE, count down and capture in WAIT,
  // download overrides everything and drops all latches
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    dout_d     = dout_q;
    if (downloading) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      valid_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_d    = WAIT;
            rom_addr_d = addr_a[win];
            gnt_d      = win;
            last_d     = win;
            cnt_d      = 2'(LAT);
            busy_d     = 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            // Tag with the issued address so a requester that moved on
            // never sees a false completion
            dout_d[gnt_q]  = bus.rom_data;
            tag_d[gnt_q]   = rom_addr_q;
            valid_d[gnt_q] = 1'b1;
            busy_d         = 1'b0;
            state_d        = IDLE;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and latch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      last_q     <= IW'(NREQ - 1);
      gnt_q      <= '0;
      valid_q    <= '0;
      tag_q      <= '{default: '0};
      dout_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.data_ok  = hit;
  assign bus.rom_addr = rom_addr_q;
  assign bus.busy     = busy_q;

  // Pack the per-requester latches onto the output bus
  always_comb begin
    bus.dout = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.dout[i*DW +: DW] = dout_q[i];
    end
  end
endmodule

// File: tb/tb_jt1942_rom_arb.sv
// Bench for jt1942_rom_arb: per-cycle vector table, directed corner-case
// sequences, and a randomized run against a transaction-level model.
module tb_jt1942_rom_arb;
  localparam int AW = 17;
  localparam int DW = 16;

  logic clk;
  logic rst_n;
  logic downloading;

  jt1942_rom_arb_if #(.NREQ(4), .AW(AW), .DW(DW)) bus1 ();
  jt1942_rom_arb_if #(.NREQ(4), .AW(AW), .DW(DW)) bus3 ();

  jt1942_rom_arb #(.NREQ(4), .AW(AW), .DW(DW), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .bus(bus1));
  jt1942_rom_arb #(.NREQ(4), .AW(AW), .DW(DW), .LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: fixed word at 0x123, a bijective scramble elsewhere
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    logic [DW-1:0] m;
    m = a[15:0] * 16'd40503;
    return (a == 17'h00123) ? 16'hBEEF : (m ^ 16'h1D2C ^ {15'd0, a[16]});
  endfunction

  // Registered ROM arrays with 1 and 3 clocks of latency
  logic [AW-1:0] pipe1;
  logic [AW-1:0] pipe3 [3];
  always @(posedge clk) begin
    pipe1    <= bus1.rom_addr;
    pipe3[0] <= bus3.rom_addr;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus1.rom_data = rom_fn(pipe1);
  assign bus3.rom_data = rom_fn(pipe3[2]);

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0]    t_req;
  logic [AW-1:0] t_addr [4];
  logic          t_dl;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic drive();
    bus1.req    = t_req;
    bus1.addr   = {t_addr[3], t_addr[2], t_addr[1], t_addr[0]};
    downloading = t_dl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    t_req = '0;
    t_dl  = 1'b0;
    for (int i = 0; i < 4; i++) t_addr[i] = '0;
    drive();
    bus3.req  = '0;
    bus3.addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cyc_chk(input string nm, input logic [3:0] e_ok, input logic e_busy,
                         input logic [AW-1:0] e_rom);
    drive();
    #1;
    chk({nm, ".data_ok"},  64'(bus1.data_ok),  64'(e_ok));
    chk({nm, ".busy"},     64'(bus1.busy),     64'(e_busy));
    chk({nm, ".rom_addr"}, 64'(bus1.rom_addr), 64'(e_rom));
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] dslice(input int i);
    return bus1.dout[i*DW +: DW];
  endfunction

  // Vector table: one row per clock cycle
  typedef struct {
    bit            rst;
    logic [3:0]    req;
    logic [AW-1:0] a0, a1, a2, a3;
    logic [3:0]    ok;
    logic          busy;
    logic [AW-1:0] rom;
    logic [DW-1:0] d1;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(bit rst, logic [3:0] req, logic [AW-1:0] a0, logic [AW-1:0] a1,
                              logic [AW-1:0] a2, logic [AW-1:0] a3, logic [3:0] ok,
                              logic busy, logic [AW-1:0] rom, logic [DW-1:0] d1);
    vec_t v;
    v.rst = rst; v.req = req; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3;
    v.ok = ok; v.busy = busy; v.rom = rom; v.d1 = d1;
    return v;
  endfunction

  // Transaction-level reference: port owner with absolute completion time
  bit            m_valid [4];
  logic [AW-1:0] m_tag   [4];
  logic [DW-1:0] m_data  [4];
  logic [AW-1:0] m_rom;
  int            m_owner, m_done, m_last, m_cyc;

  function automatic bit m_hit(input int i);
    return t_req[i] && m_valid[i] && (m_tag[i] == t_addr[i]) && !t_dl;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
    end
    m_rom = '0; m_owner = -1; m_done = 0; m_last = 3; m_cyc = 0;
  endtask

  task automatic model_step();
    m_cyc++;
    if (t_dl) begin
      m_owner = -1;
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    end else if (m_owner >= 0) begin
      if (m_cyc == m_done) begin
        m_valid[m_owner] = 1'b1;
        m_tag[m_owner]   = m_rom;
        m_data[m_owner]  = rom_fn(m_rom);
        m_owner = -1;
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int j;
        j = (m_last + k) % 4;
        if (t_req[j] && !m_hit(j)) begin
          m_owner = j; m_rom = t_addr[j]; m_last = j; m_done = m_cyc + 2;
          break;
        end
      end
    end
  endtask

  initial begin
    logic [3:0]    e_ok;
    logic [63:0]   e_dout;
    int            dl_left;

    rst_n = 1'b0;
    t_req = '0; t_dl = 1'b0;
    for (int i = 0; i < 4; i++) t_addr[i] = '0;
    drive();
    bus3.req = '0; bus3.addr = '0;

    // Single miss, re-hit, fairness and round-robin resume
    tv.push_back(mk(1, 4'b0010, 17'h0, 17'h123, 17'h0, 17'h0, 4'b0000, 0, 17'h0,   16'h0));
    tv.push_back(mk(0, 4'b0010, 17'h0, 17'h123, 17'h0, 17'h0, 4'b0000, 1, 17'h123, 16'h0));
    tv.push_back(mk(0, 4'b0010, 17'h0, 17'h123, 17'h0, 17'h0, 4'b0000, 1, 17'h123, 16'h0));
    tv.push_back(mk(0, 4'b0010, 17'h0, 17'h123, 17'h0, 17'h0, 4'b0010, 0, 17'h123, 16'hBEEF));
    tv.push_back(mk(0, 4'b0000, 17'h0, 17'h123, 17'h0, 17'h0, 4'b0000, 0, 17'h123, 16'hBEEF));
    tv.push_back(mk(0, 4'b0010, 17'h0, 17'h123, 17'h0, 17'h0, 4'b0010, 0, 17'h123, 16'hBEEF));
    tv.push_back(mk(0, 4'b0010, 17'h0, 17'h123, 17'h0, 17'h0, 4'b0010, 0, 17'h123, 16'hBEEF));
    tv.push_back(mk(1, 4'b1111, 17'h10, 17'h11, 17'h12, 17'h13, 4'b0000, 0, 17'h0,  16'h0));
    tv.push_back(mk(0, 4'b1111, 17'h10, 17'h11, 17'h12, 17'h13, 4'b0000, 1, 17'h10, 16'h0));
    tv.push_back(mk(0, 4'b1111, 17'h10, 17'h11, 17'h12, 17'h13, 4'b0000, 1, 17'h10, 16'h0));
    tv.push_back(mk(0, 4'b1111, 17'h10, 17'h11, 17'h12, 17'h13, 4'b0001, 0, 17'h10, 16'h0));
    tv.push_back(mk(0, 4'b1111, 17'h10, 17'h11, 17'h12, 17'h13, 4'b0001, 1, 17'h11, 16'h0));
    tv.push_back(mk(0, 4'b1111, 17'h10, 17'h11, 17'h12, 17'h13, 4'b0001, 1, 17'h11, 16'h0));
    tv.push_back(mk(0, 4'b1111, 17'h10, 17'h11, 17'h12, 17'h13, 4'b0011, 0, 17'h11, rom_fn(17'h11)));
    tv.push_back(mk(0, 4'b1111, 17'h10, 17'h11, 17'h12, 17'h13, 4'b0011, 1, 17'h12, rom_fn(17'h11)));
    tv.push_back(mk(0, 4'b1111, 17'h10, 17'h11, 17'h12, 17'h13, 4'b0011, 1, 17'h12, rom_fn(17'h11)));
    tv.push_back(mk(0, 4'b1111, 17'h10, 17'h11, 17'h12, 17'h13, 4'b0111, 0, 17'h12, rom_fn(17'h11)));
    tv.push_back(mk(0, 4'b1111, 17'h10, 17'h11, 17'h12, 17'h13, 4'b0111, 1, 17'h13, rom_fn(17'h11)));
    tv.push_back(mk(0, 4'b1111, 17'h10, 17'h11, 17'h12, 17'h13, 4'b0111, 1, 17'h13, rom_fn(17'h11)));
    tv.push_back(mk(0, 4'b1111, 17'h10, 17'h11, 17'h12, 17'h13, 4'b1111, 0, 17'h13, rom_fn(17'h11)));
    tv.push_back(mk(0, 4'b0000, 17'h10, 17'h11, 17'h12, 17'h13, 4'b0000, 0, 17'h13, rom_fn(17'h11)));
    tv.push_back(mk(0, 4'b0101, 17'h20, 17'h11, 17'h22, 17'h13, 4'b0000, 0, 17'h13, rom_fn(17'h11)));
    tv.push_back(mk(0, 4'b0101, 17'h20, 17'h11, 17'h22, 17'h13, 4'b0000, 1, 17'h20, rom_fn(17'h11)));
    tv.push_back(mk(0, 4'b0101, 17'h20, 17'h11, 17'h22, 17'h13, 4'b0000, 1, 17'h20, rom_fn(17'h11)));
    tv.push_back(mk(0, 4'b0101, 17'h20, 17'h11, 17'h22, 17'h13, 4'b0001, 0, 17'h20, rom_fn(17'h11)));
    tv.push_back(mk(0, 4'b0101, 17'h20, 17'h11, 17'h22, 17'h13, 4'b0001, 1, 17'h22, rom_fn(17'h11)));
    tv.push_back(mk(0, 4'b0101, 17'h20, 17'h11, 17'h22, 17'h13, 4'b0001, 1, 17'h22, rom_fn(17'h11)));
    tv.push_back(mk(0, 4'b0101, 17'h20, 17'h11, 17'h22, 17'h13, 4'b0101, 0, 17'h22, rom_fn(17'h11)));

    // Reset state
    @(negedge clk);
    #1;
    chk("reset.data_ok",  64'(bus1.data_ok),  64'(4'b0000));
    chk("reset.busy",     64'(bus1.busy),     64'(1'b0));
    chk("reset.rom_addr", 64'(bus1.rom_addr), 64'(17'h0));
    chk("reset.dout",     bus1.dout,          64'h0);
    chk("reset.busy3",    64'(bus3.busy),     64'(1'b0));

    for (int k = 0; k < tv.size(); k++) begin
      if (tv[k].rst) do_reset();
      t_req = tv[k].req;
      t_addr[0] = tv[k].a0; t_addr[1] = tv[k].a1; t_addr[2] = tv[k].a2; t_addr[3] = tv[k].a3;
      cyc_chk($sformatf("vec%0d", k), tv[k].ok, tv[k].busy, tv[k].rom);
      chk($sformatf("vec%0d.dout1", k), 64'(dslice(1)), 64'(tv[k].d1));
      adv();
    end

    // Download abort in WAIT, then re-grant; download clears latches
    do_reset();
    t_req = 4'b0100; t_addr[2] = 17'h55;
    cyc_chk("dl_c0", 4'b0000, 1'b0, 17'h0);   adv();
    t_dl = 1'b1;
    cyc_chk("dl_c1", 4'b0000, 1'b1, 17'h55);  adv();
    cyc_chk("dl_c2", 4'b0000, 1'b0, 17'h55);
    chk("dl_c2.dout2", 64'(dslice(2)), 64'(16'h0));                  adv();
    t_dl = 1'b0;
    cyc_chk("dl_c3", 4'b0000, 1'b0, 17'h55);  adv();
    cyc_chk("dl_c4", 4'b0000, 1'b1, 17'h55);  adv();
    cyc_chk("dl_c5", 4'b0000, 1'b1, 17'h55);  adv();
    cyc_chk("dl_c6", 4'b0100, 1'b0, 17'h55);
    chk("dl_c6.dout2", 64'(dslice(2)), 64'(rom_fn(17'h55)));         adv();
    t_dl = 1'b1;
    cyc_chk("dl_c7", 4'b0000, 1'b0, 17'h55);  adv();
    t_dl = 1'b0;
    cyc_chk("dl_c8", 4'b0000, 1'b0, 17'h55);  adv();
    cyc_chk("dl_c9", 4'b0000, 1'b1, 17'h55);  adv();
    cyc_chk("dl_c10", 4'b0000, 1'b1, 17'h55); adv();
    cyc_chk("dl_c11", 4'b0100, 1'b0, 17'h55); adv();

    // Address change in flight, req drop in flight, latch life, async reset
    do_reset();
    t_req = 4'b0001; t_addr[0] = 17'h10;
    cyc_chk("ac_c0", 4'b0000, 1'b0, 17'h0);
    adv();
    cyc_chk("ac_c1", 4'b0000, 1'b1, 17'h10);
    t_addr[0] = 17'h20; drive();
    adv();
    cyc_chk("ac_c2", 4'b0000, 1'b1, 17'h10);  adv();
    cyc_chk("ac_c3", 4'b0000, 1'b0, 17'h10);  adv();
    cyc_chk("ac_c4", 4'b0000, 1'b1, 17'h20);  adv();
    cyc_chk("ac_c5", 4'b0000, 1'b1, 17'h20);  adv();
    cyc_chk("ac_c6", 4'b0001, 1'b0, 17'h20);
    chk("ac_c6.dout0", 64'(dslice(0)), 64'(rom_fn(17'h20)));
    adv();
    t_req = 4'b0011; t_addr[1] = 17'h40;
    cyc_chk("rd_c7", 4'b0001, 1'b0, 17'h20);
    adv();
    cyc_chk("rd_c8", 4'b0001, 1'b1, 17'h40);
    t_req = 4'b0001; drive();
    adv();
    cyc_chk("rd_c9", 4'b0001, 1'b1, 17'h40);  adv();
    cyc_chk("rd_c10", 4'b0001, 1'b0, 17'h40);
    chk("rd_c10.dout1", 64'(dslice(1)), 64'(rom_fn(17'h40)));
    adv();
    t_req = 4'b0011;
    cyc_chk("rd_c11", 4'b0011, 1'b0, 17'h40); adv();
    t_req = 4'b0111; t_addr[2] = 17'h33;
    cyc_chk("ar_c12", 4'b0011, 1'b0, 17'h40); adv();
    cyc_chk("ar_c13", 4'b0011, 1'b1, 17'h33);
    rst_n = 1'b0;
    #1;
    chk("async.busy",     64'(bus1.busy),     64'(1'b0));
    chk("async.rom_addr", 64'(bus1.rom_addr), 64'(17'h0));
    chk("async.data_ok",  64'(bus1.data_ok),  64'(4'b0000));
    chk("async.dout",     bus1.dout,          64'h0);
    adv();

    // LAT=3 instance: single miss completes in cycle 5
    do_reset();
    bus3.req  = 4'b0010;
    bus3.addr = {17'h0, 17'h0, 17'h123, 17'h0};
    for (int c = 0; c < 7; c++) begin
      #1;
      chk($sformatf("lat3_c%0d.data_ok", c), 64'(bus3.data_ok),
          64'((c >= 5) ? 4'b0010 : 4'b0000));
      chk($sformatf("lat3_c%0d.busy", c), 64'(bus3.busy), 64'((c >= 1 && c <= 4) ? 1'b1 : 1'b0));
      if (c == 1) chk("lat3_c1.rom_addr", 64'(bus3.rom_addr), 64'(17'h123));
      if (c == 5) chk("lat3_c5.dout1", 64'(bus3.dout[DW +: DW]), 64'(16'hBEEF));
      adv();
    end

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    e_ok = '0;
    dl_left = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (t_req[i]) begin
          if (e_ok[i] && $urandom_range(0, 1) == 0) t_req[i] = 1'b0;
          else if ($urandom_range(0, 49) == 0) t_addr[i] = AW'($urandom_range(0, 7));
          else if ($urandom_range(0, 49) == 0) t_req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          t_req[i]  = 1'b1;
          t_addr[i] = AW'($urandom_range(0, 7));
        end
      end
      if (dl_left == 0 && $urandom_range(0, 99) == 0) dl_left = $urandom_range(1, 3);
      t_dl = (dl_left > 0);
      if (dl_left > 0) dl_left--;
      drive();
      #1;
      for (int i = 0; i < 4; i++) begin
        e_ok[i] = m_hit(i);
        e_dout[i*DW +: DW] = m_data[i];
      end
      chk($sformatf("rnd%0d.data_ok", c),  64'(bus1.data_ok),  64'(e_ok));
      chk($sformatf("rnd%0d.busy", c),     64'(bus1.busy),     64'(m_owner >= 0));
      chk($sformatf("rnd%0d.rom_addr", c), 64'(bus1.rom_addr), 64'(m_rom));
      chk($sformatf("rnd%0d.dout", c),     bus1.dout,          e_dout);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
